local_bias_ctrl: RTL and testbench



---
 rtl/local_bias_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_local_bias_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/local_bias_ctrl.sv
// Power-up sequencer and testbus monitor for a local bias generator: brings
// the block up, range-checks supply/ground/bias-current readings, reports ready or a coded fault.
module local_bias_ctrl #(
  parameter int  SETTLE_CYC     = 16,
  parameter int  ATB_SETTLE_CYC = 4,
  parameter int  RECHECK_CYC    = 0,
  parameter real VTOL           = 0.05,
  parameter real VSS_ABS        = 0.05,
  parameter real ITOL           = 0.10
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  real        atb1,
  input  real        atb0,
  output logic       pdb,
  output logic [0:1] atb_ena,
  output logic       busy,
  output logic       bias_ok,
  output logic       bias_fail,
  output logic [2:0] fail_code
);

  localparam int MAX_AB = (SETTLE_CYC > ATB_SETTLE_CYC) ? SETTLE_CYC : ATB_SETTLE_CYC;
  localparam int MAXC   = (MAX_AB > RECHECK_CYC) ? MAX_AB : RECHECK_CYC;
  localparam int CNT_W  = $clog2(MAXC + 1);

  localparam real V18_LO = 1.8 * (1.0 - VTOL);
  localparam real V18_HI = 1.8 * (1.0 + VTOL);
  localparam real V08_LO = 0.8 * (1.0 - VTOL);
  localparam real V08_HI = 0.8 * (1.0 + VTOL);
  localparam real I25_LO = 25.0e-6 * (1.0 - ITOL);
  localparam real I25_HI = 25.0e-6 * (1.0 + ITOL);
  localparam real I500_LO = 500.0e-6 * (1.0 - ITOL);
  localparam real I500_HI = 500.0e-6 * (1.0 + ITOL);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_CHK_SUP, S_CHK_GND, S_CHK_BIAS, S_READY, S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pdb_q, pdb_d;
  logic [0:1]       atb_ena_q, atb_ena_d;
  logic             busy_q, busy_d;
  logic             bias_ok_q, bias_ok_d;
  logic             bias_fail_q, bias_fail_d;
  logic [2:0]       fail_code_q, fail_code_d;
  logic             atb_done;
  logic             chk_fail;
  logic [2:0]       chk_code;

  // NaN (how an undriven real net is represented) compares false, so it fails.
  function automatic logic in_win(input real v, input real lo, input real hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign atb_done = (cnt_q == CNT_W'(ATB_SETTLE_CYC - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pdb_q       <= 1'b0;
      atb_ena_q   <= 2'b00;
      busy_q      <= 1'b0;
      bias_ok_q   <= 1'b0;
      bias_fail_q <= 1'b0;
      fail_code_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pdb_q       <= pdb_d;
      atb_ena_q   <= atb_ena_d;
      busy_q      <= busy_d;
      bias_ok_q   <= bias_ok_d;
      bias_fail_q <= bias_fail_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pdb_d       = pdb_q;
    atb_ena_d   = atb_ena_q;
    busy_d      = busy_q;
    bias_ok_d   = bias_ok_q;
    bias_fail_d = bias_fail_q;
    fail_code_d = fail_code_q;
    chk_fail    = 1'b0;
    chk_code    = 3'd0;

    if (state_q != S_IDLE && !en) begin
      // Power-down wins over any sample falling due on this edge.
      state_d     = S_IDLE;
      cnt_d       = '0;
      pdb_d       = 1'b0;
      atb_ena_d   = 2'b00;
      busy_d      = 1'b0;
      bias_ok_d   = 1'b0;
      bias_fail_d = 1'b0;
      fail_code_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_d = S_PWRUP;
            cnt_d   = '0;
            pdb_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
        S_PWRUP: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            state_d   = S_CHK_SUP;
            cnt_d     = '0;
            atb_ena_d = 2'b01;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_CHK_SUP: begin
          if (!atb_done) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            if (!in_win(atb1, V18_LO, V18_HI)) begin
              chk_fail = 1'b1;
              chk_code = 3'd1;
            end else if (!in_win(atb0, V08_LO, V08_HI)) begin
              chk_fail = 1'b1;
              chk_code = 3'd2;
            end else begin
              state_d   = S_CHK_GND;
              atb_ena_d = 2'b10;
            end
          end
        end
        S_CHK_GND: begin
          if (!atb_done) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            if (!in_win(atb1, -VSS_ABS, VSS_ABS) || !in_win(atb0, -VSS_ABS, VSS_ABS)) begin
              chk_fail = 1'b1;
              chk_code = 3'd3;
            end else begin
              state_d   = S_CHK_BIAS;
              atb_ena_d = 2'b11;
            end
          end
        end
        S_CHK_BIAS: begin
          if (!atb_done) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            if (!in_win(atb1, I25_LO, I25_HI)) begin
              chk_fail = 1'b1;
              chk_code = 3'd4;
            end else if (!in_win(atb0, I500_LO, I500_HI)) begin
              chk_fail = 1'b1;
              chk_code = 3'd5;
            end else begin
              state_d   = S_READY;
              atb_ena_d = 2'b00;
              busy_d    = 1'b0;
              bias_ok_d = 1'b1;
            end
          end
        end
        S_READY: begin
          // bias_ok is left untouched so it stays high through a re-check.
          if (RECHECK_CYC > 0) begin
            if (cnt_q == CNT_W'(RECHECK_CYC - 1)) begin
              state_d   = S_CHK_SUP;
              cnt_d     = '0;
              atb_ena_d = 2'b01;
              busy_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (chk_fail) begin
        state_d     = S_FAIL;
        pdb_d       = 1'b0;
        atb_ena_d   = 2'b00;
        busy_d      = 1'b0;
        bias_ok_d   = 1'b0;
        bias_fail_d = 1'b1;
        fail_code_d = chk_code;
      end
    end
  end

  assign pdb       = pdb_q;
  assign atb_ena   = atb_ena_q;
  assign busy      = busy_q;
  assign bias_ok   = bias_ok_q;
  assign bias_fail = bias_fail_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Bench for local_bias_ctrl: a behavioural bias block answers each testbus mode,
// table vectors run through a per-cycle scoreboard, hand sequences cover re-check/abort/reset.
module tb_local_bias_ctrl;

  logic       clk = 1'b0;
  logic       rstb, en;
  real        atb1, atb0;
  logic       pdb, busy, bias_ok, bias_fail;
  logic [0:1] atb_ena;
  logic [2:0] fail_code;
  logic       pdb0, busy0, bias_ok0, bias_fail0;
  logic [0:1] atb_ena0;
  logic [2:0] fail_code0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  local_bias_ctrl #(.RECHECK_CYC(10)) dut (
    .clk(clk), .rstb(rstb), .en(en), .atb1(atb1), .atb0(atb0),
    .pdb(pdb), .atb_ena(atb_ena), .busy(busy), .bias_ok(bias_ok),
    .bias_fail(bias_fail), .fail_code(fail_code)
  );

  local_bias_ctrl dut0 (
    .clk(clk), .rstb(rstb), .en(en), .atb1(atb1), .atb0(atb0),
    .pdb(pdb0), .atb_ena(atb_ena0), .busy(busy0), .bias_ok(bias_ok0),
    .bias_fail(bias_fail0), .fail_code(fail_code0)
  );

  // Bias block model: readings per testbus mode, overridable for fault injection.
  real s1, s0, g1, g0, b1, b0;
  always_comb begin
    case (atb_ena)
      2'b01:   begin atb1 = s1;  atb0 = s0;  end
      2'b10:   begin atb1 = g1;  atb0 = g0;  end
      2'b11:   begin atb1 = b1;  atb0 = b0;  end
      default: begin atb1 = 0.0; atb0 = 0.0; end
    endcase
  end

  typedef struct {
    real s1, s0, g1, g0, b1, b0;
    int  code;
  } vec_t;

  vec_t       vecs[10];
  logic [8:0] sb_q[$];
  real        nan_r;

  function automatic logic [8:0] pack1();
    return {pdb, atb_ena, busy, bias_ok, bias_fail, fail_code};
  endfunction

  function automatic logic [8:0] pack0();
    return {pdb0, atb_ena0, busy0, bias_ok0, bias_fail0, fail_code0};
  endfunction

  // Expected {pdb,atb_ena,busy,bias_ok,bias_fail,fail_code} k edges after en=1 is sampled.
  function automatic logic [8:0] expect_at(int k, int code);
    int         fk;
    logic [1:0] ena;
    logic       p, b, ok, f;
    fk  = (code == 0) ? 1000 : (code <= 2) ? 20 : (code == 3) ? 24 : 28;
    f   = (k >= fk);
    p   = !f;
    b   = !f && (k < 28);
    ok  = (code == 0) && (k >= 28);
    if (f || k < 16 || k >= 28) ena = 2'b00;
    else if (k < 20)            ena = 2'b01;
    else if (k < 24)            ena = 2'b10;
    else                        ena = 2'b11;
    return {p, ena, b, ok, f, (f ? 3'(code) : 3'd0)};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_nominal();
    s1 = 1.8; s0 = 0.8; g1 = 0.0; g0 = 0.0; b1 = 25.0e-6; b0 = 500.0e-6;
  endtask

  // Push the expected trace, raise en, then pop and compare once per cycle.
  task automatic run_seq(input int id, input int code, input int n);
    logic [8:0] e;
    for (int k = 0; k <= n; k++) sb_q.push_back(expect_at(k, code));
    en = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("seq%0d k=%0d", id, k), pack1(), e);
      chk($sformatf("seq%0d k=%0d dut0", id, k), pack0(), e);
      $display("seq%0d k=%0d out=%03h exp=%03h", id, k, pack1(), e);
    end
  endtask

  initial begin
    nan_r = $bitstoreal(64'h7FF8_0000_0000_0000);
    set_nominal();
    vecs[0] = '{1.8,   0.8,   0.0,   0.0,   25.0e-6, 500.0e-6, 0};
    vecs[1] = '{1.70,  0.8,   0.0,   0.0,   25.0e-6, 500.0e-6, 1};
    vecs[2] = '{1.8,   0.84,  0.0,   0.0,   25.0e-6, 500.0e-6, 0};
    vecs[3] = '{1.8,   0.841, 0.0,   0.0,   25.0e-6, 500.0e-6, 2};
    vecs[4] = '{1.8,   0.8,   0.0,   0.06,  25.0e-6, 500.0e-6, 3};
    vecs[5] = '{1.8,   0.8,   -0.05, 0.05,  25.0e-6, 500.0e-6, 0};
    vecs[6] = '{1.8,   0.8,   0.0,   0.0,   nan_r,   500.0e-6, 4};
    vecs[7] = '{1.8,   0.8,   0.0,   0.0,   25.0e-6, 0.0,      5};
    vecs[8] = '{1.5,   0.5,   0.0,   0.0,   25.0e-6, 500.0e-6, 1};
    vecs[9] = '{1.8,   nan_r, 0.0,   0.0,   25.0e-6, 500.0e-6, 2};

    rstb = 1'b0;
    en   = 1'b0;
    step(2);
    chk("reset", pack1(), 9'h000);
    chk("reset dut0", pack0(), 9'h000);
    rstb = 1'b1;
    step(1);

    for (int i = 0; i < 10; i++) begin
      s1 = vecs[i].s1; s0 = vecs[i].s0; g1 = vecs[i].g1;
      g0 = vecs[i].g0; b1 = vecs[i].b1; b0 = vecs[i].b0;
      run_seq(i, vecs[i].code, 30);
      en = 1'b0;
      step(1);
      chk($sformatf("vec%0d en0 clear", i), pack1(), 9'h000);
      $display("vec%0d done code=%0d fail_code=%0d", i, vecs[i].code, fail_code);
      set_nominal();
    end

    // Periodic re-check, then a bias-current fault during it.
    run_seq(20, 0, 28);
    step(9);
    chk("ready before recheck", pack1(), {1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0});
    step(1);
    chk("recheck entry", pack1(), {1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 3'd0});
    chk("no recheck dut0", pack0(), {1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0});
    $display("recheck entry out=%03h dut0=%03h", pack1(), pack0());
    b0 = 0.0;
    step(11);
    chk("recheck mode11", pack1(), {1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 3'd0});
    step(1);
    chk("recheck fail", pack1(), {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd5});
    $display("recheck fail out=%03h", pack1());
    en = 1'b0;
    step(1);
    chk("recheck clear", pack1(), 9'h000);
    set_nominal();

    // Abort mid-check, restart, then asynchronous reset mid-sequence.
    en = 1'b1;
    step(18);
    chk("abort pre", pack1(), {1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 3'd0});
    en = 1'b0;
    step(1);
    chk("abort idle", pack1(), 9'h000);
    $display("abort out=%03h", pack1());
    en = 1'b1;
    step(23);
    chk("restart k22", pack1(), {1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'd0});
    #2 rstb = 1'b0;
    #1 chk("async reset", pack1(), 9'h000);
    $display("async reset out=%03h", pack1());
    step(2);
    chk("held reset", pack1(), 9'h000);
    rstb = 1'b1;
    run_seq(30, 0, 28);

    en = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
